// File: rtl/radix_4_ntt_ctrl.sv
// Radix-4 NTT/INTT butterfly sequencer: issues one butterfly per cycle with operand and twiddle
// addresses, then delays the read addresses into matching write-back addresses.
//
// state    | meaning
// st_idle  | waiting for start
// st_issue | one butterfly read per cycle, b = 0..N/4-1
// st_drain | lat empty cycles so the stage's last write lands before the next stage reads
// st_done  | one-cycle done pulse
module radix_4_ntt_ctrl #(
   parameter int width  = 32,
   parameter int log4_n = 2,
   parameter int lat    = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     select,
   output logic                     busy,
   output logic                     done,
   output logic                     bf_select,
   output logic [$clog2(log4_n):0]  stage,
   output logic                     rd_en,
   output logic [2*log4_n-1:0]      rd_addr_0,
   output logic [2*log4_n-1:0]      rd_addr_1,
   output logic [2*log4_n-1:0]      rd_addr_2,
   output logic [2*log4_n-1:0]      rd_addr_3,
   output logic [2*log4_n-1:0]      tw_addr_1,
   output logic [2*log4_n-1:0]      tw_addr_2,
   output logic [2*log4_n-1:0]      tw_addr_3,
   output logic                     wr_en,
   output logic [2*log4_n-1:0]      wr_addr_0,
   output logic [2*log4_n-1:0]      wr_addr_1,
   output logic [2*log4_n-1:0]      wr_addr_2,
   output logic [2*log4_n-1:0]      wr_addr_3
);

   localparam int aw    = 2 * log4_n;
   localparam int sw    = $clog2(log4_n) + 1;
   localparam int n_pts = 1 << aw;
   localparam int bw    = (aw > 2) ? aw - 2 : 1;
   localparam int dw    = (lat > 1) ? $clog2(lat) : 1;
   localparam logic [bw-1:0] b_last     = bw'(n_pts / 4 - 1);
   localparam logic [sw-1:0] stage_last = sw'(log4_n - 1);

   if (lat < 1 || width < 1) begin : g_param_check
      $error("radix_4_ntt_ctrl: lat and width must be at least 1");
   end

   typedef enum logic [1:0] {st_idle, st_issue, st_drain, st_done} state_t;

   state_t          state;
   logic [bw-1:0]   b_cnt;
   logic [dw-1:0]   drain_cnt;
   logic [aw-1:0]   rd_addr [4];
   logic [aw-1:0]   tw_addr [3];
   logic            pipe_en   [lat];
   logic [aw-1:0]   pipe_addr [lat][4];

   logic            issue_next;
   logic            gen_sel;
   logic [bw-1:0]   gen_b;
   logic [sw-1:0]   gen_stage;
   logic [sw-1:0]   gen_t;
   logic [sw:0]     span_sh;
   logic [sw:0]     tw_sh;
   logic [aw-1:0]   b_ext;
   logic [aw-1:0]   j_idx;
   logic [aw-1:0]   g_idx;
   logic [aw-1:0]   base;
   logic [aw-1:0]   gen_rd [4];
   logic [aw-1:0]   gen_tw [3];

   // Addresses are computed for the butterfly that will be issued next cycle.
   always_comb begin
      gen_sel   = bf_select;
      gen_b     = '0;
      gen_stage = stage;
      case (state)
         st_idle: begin
            gen_sel   = select;
            gen_stage = '0;
         end
         st_issue: gen_b     = b_cnt + bw'(1);
         st_drain: gen_stage = stage + sw'(1);
         default: ;
      endcase
      issue_next = ((state == st_idle) && start) ||
                   ((state == st_issue) && (b_cnt != b_last)) ||
                   ((state == st_drain) && (drain_cnt == '0) && (stage != stage_last));

      // t = log4(span): NTT spans shrink stage by stage, INTT spans grow.
      gen_t   = gen_sel ? gen_stage : stage_last - gen_stage;
      span_sh = {gen_t, 1'b0};
      tw_sh   = {stage_last - gen_t, 1'b0};
      b_ext   = aw'(gen_b);
      j_idx   = b_ext & ((aw'(1) << span_sh) - aw'(1));
      g_idx   = b_ext >> span_sh;
      base    = (g_idx << (span_sh + 2)) | j_idx;
      for (int m = 0; m < 4; m++) gen_rd[m] = base | (aw'(m) << span_sh);
      for (int m = 0; m < 3; m++) gen_tw[m] = (j_idx * aw'(m + 1)) << tw_sh;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= st_idle;
         busy      <= 1'b0;
         done      <= 1'b0;
         bf_select <= 1'b0;
         stage     <= '0;
         rd_en     <= 1'b0;
         b_cnt     <= '0;
         drain_cnt <= '0;
         for (int m = 0; m < 4; m++) rd_addr[m] <= '0;
         for (int m = 0; m < 3; m++) tw_addr[m] <= '0;
         for (int i = 0; i < lat; i++) begin
            pipe_en[i] <= 1'b0;
            for (int m = 0; m < 4; m++) pipe_addr[i][m] <= '0;
         end
      end else begin
         pipe_en[0] <= rd_en;
         for (int m = 0; m < 4; m++) pipe_addr[0][m] <= rd_addr[m];
         for (int i = 1; i < lat; i++) begin
            pipe_en[i] <= pipe_en[i-1];
            for (int m = 0; m < 4; m++) pipe_addr[i][m] <= pipe_addr[i-1][m];
         end

         rd_en <= issue_next;
         if (issue_next) begin
            for (int m = 0; m < 4; m++) rd_addr[m] <= gen_rd[m];
            for (int m = 0; m < 3; m++) tw_addr[m] <= gen_tw[m];
         end

         case (state)
            st_idle: begin
               done <= 1'b0;
               if (start) begin
                  bf_select <= select;
                  stage     <= '0;
                  b_cnt     <= '0;
                  busy      <= 1'b1;
                  state     <= st_issue;
               end
            end
            st_issue: begin
               if (b_cnt == b_last) begin
                  drain_cnt <= dw'(lat - 1);
                  state     <= st_drain;
               end else begin
                  b_cnt <= b_cnt + bw'(1);
               end
            end
            st_drain: begin
               if (drain_cnt == '0) begin
                  if (stage == stage_last) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= st_done;
                  end else begin
                     stage <= stage + sw'(1);
                     b_cnt <= '0;
                     state <= st_issue;
                  end
               end else begin
                  drain_cnt <= drain_cnt - dw'(1);
               end
            end
            default: begin
               done  <= 1'b0;
               state <= st_idle;
            end
         endcase
      end
   end

   assign rd_addr_0 = rd_addr[0];
   assign rd_addr_1 = rd_addr[1];
   assign rd_addr_2 = rd_addr[2];
   assign rd_addr_3 = rd_addr[3];
   assign tw_addr_1 = tw_addr[0];
   assign tw_addr_2 = tw_addr[1];
   assign tw_addr_3 = tw_addr[2];
   assign wr_en     = pipe_en[lat-1];
   assign wr_addr_0 = pipe_addr[lat-1][0];
   assign wr_addr_1 = pipe_addr[lat-1][1];
   assign wr_addr_2 = pipe_addr[lat-1][2];
   assign wr_addr_3 = pipe_addr[lat-1][3];

endmodule
